// File: rtl/ram_access_arbiter.sv
// Arbitrates a CPU port and a host loader port onto one 16x8 synchronous RAM.
// Optional round-robin tie-breaking is enabled by defining ARB_ROUND_ROBIN_EN.
module ram_access_arbiter (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       cpu_req_i,
  input  logic       cpu_we_i,
  input  logic [3:0] cpu_addr_i,
  input  logic [7:0] cpu_wdata_i,
  output logic       cpu_gnt_o,
  output logic       cpu_valid_o,
  output logic [7:0] cpu_rdata_o,
  input  logic       host_req_i,
  input  logic       host_we_i,
  input  logic [3:0] host_addr_i,
  input  logic [7:0] host_wdata_i,
  input  logic       host_lock_i,
  output logic       host_gnt_o,
  output logic       host_valid_o,
  output logic [7:0] host_rdata_o,
  output logic       cpu_halt_o,
  output logic       ram_en_o,
  output logic       ram_we_o,
  output logic [3:0] ram_addr_o,
  output logic [7:0] ram_wdata_o,
  input  logic [7:0] ram_rdata_i
);

  // state    | meaning
  // IDLE     | no access in flight, arbitrate between requesters
  // GNT_CPU  | CPU access on the RAM port this cycle
  // GNT_HOST | host access on the RAM port this cycle
  // LOCKED   | host holds the RAM for a burst, CPU halted
  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_HOST, LOCKED} state_e;

  state_e     state_q, state_d;
  logic       cpu_gnt_q, cpu_gnt_d;
  logic       host_gnt_q, host_gnt_d;
  logic       cpu_valid_q, cpu_valid_d;
  logic       host_valid_q, host_valid_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] host_rdata_q, host_rdata_d;
  logic       cpu_halt_q, cpu_halt_d;
  logic       ram_en_q, ram_en_d;
  logic       ram_we_q, ram_we_d;
  logic [3:0] ram_addr_q, ram_addr_d;
  logic [7:0] ram_wdata_q, ram_wdata_d;
  logic       grant_cpu, grant_host;
  logic       host_wins_tie;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_host_q, last_host_d;

  assign host_wins_tie = !last_host_q;
  assign last_host_d   = grant_host ? 1'b1 : (grant_cpu ? 1'b0 : last_host_q);

  always_ff @(posedge clk_i) begin
    if (!resetn_i) last_host_q <= 1'b1;
    else           last_host_q <= last_host_d;
  end
`else
  assign host_wins_tie = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q      <= IDLE;
      cpu_gnt_q    <= 1'b0;
      host_gnt_q   <= 1'b0;
      cpu_valid_q  <= 1'b0;
      host_valid_q <= 1'b0;
      cpu_rdata_q  <= 8'h00;
      host_rdata_q <= 8'h00;
      cpu_halt_q   <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= 4'h0;
      ram_wdata_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      cpu_gnt_q    <= cpu_gnt_d;
      host_gnt_q   <= host_gnt_d;
      cpu_valid_q  <= cpu_valid_d;
      host_valid_q <= host_valid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
      cpu_halt_q   <= cpu_halt_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_cpu    = 1'b0;
    grant_host   = 1'b0;
    cpu_gnt_d    = 1'b0;
    host_gnt_d   = 1'b0;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    // ram_we_q still holds the captured write flag during a grant cycle
    cpu_valid_d  = (state_q == GNT_CPU) && !ram_we_q;
    host_valid_d = (state_q == GNT_HOST) && !ram_we_q;
    cpu_rdata_d  = cpu_valid_q ? ram_rdata_i : cpu_rdata_q;
    host_rdata_d = host_valid_q ? ram_rdata_i : host_rdata_q;

    case (state_q)
      IDLE: begin
        if (host_req_i && (!cpu_req_i || host_wins_tie)) grant_host = 1'b1;
        else if (cpu_req_i)                               grant_cpu  = 1'b1;
      end
      GNT_CPU:  state_d = IDLE;
      GNT_HOST: state_d = host_lock_i ? LOCKED : IDLE;
      LOCKED: begin
        if (host_req_i)        grant_host = 1'b1;
        else if (!host_lock_i) state_d    = IDLE;
      end
      default:  state_d = IDLE;
    endcase

    if (grant_cpu) begin
      state_d     = GNT_CPU;
      cpu_gnt_d   = 1'b1;
      ram_en_d    = 1'b1;
      ram_we_d    = cpu_we_i;
      ram_addr_d  = cpu_addr_i;
      ram_wdata_d = cpu_wdata_i;
    end else if (grant_host) begin
      state_d     = GNT_HOST;
      host_gnt_d  = 1'b1;
      ram_en_d    = 1'b1;
      ram_we_d    = host_we_i;
      ram_addr_d  = host_addr_i;
      ram_wdata_d = host_wdata_i;
    end

    cpu_halt_d = (state_d == LOCKED) || ((state_d == GNT_HOST) && (state_q == LOCKED));
  end

  assign cpu_gnt_o    = cpu_gnt_q;
  assign host_gnt_o   = host_gnt_q;
  assign cpu_valid_o  = cpu_valid_q;
  assign host_valid_o = host_valid_q;
  // RAM data only arrives in the valid cycle itself, so it is forwarded then and held afterwards
  assign cpu_rdata_o  = cpu_valid_q ? ram_rdata_i : cpu_rdata_q;
  assign host_rdata_o = host_valid_q ? ram_rdata_i : host_rdata_q;
  assign cpu_halt_o   = cpu_halt_q;
  assign ram_en_o     = ram_en_q;
  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: per-cycle vector table plus lock-burst and reset sequences.
// Expected values follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_ram_access_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_valid;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       host_req, host_we, host_lock, host_gnt, host_valid;
  logic [3:0] host_addr;
  logic [7:0] host_wdata, host_rdata;
  logic       cpu_halt, ram_en, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic [7:0] mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_access_arbiter dut (
    .clk_i(clk), .resetn_i(resetn),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_valid_o(cpu_valid), .cpu_rdata_o(cpu_rdata),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_lock_i(host_lock), .host_gnt_o(host_gnt), .host_valid_o(host_valid), .host_rdata_o(host_rdata),
    .cpu_halt_o(cpu_halt), .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // 16x8 synchronous RAM, read data one cycle after ram_en
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // cin = {req,we,addr,wdata}; hin = {req,we,addr,wdata,lock}
  // exp = {cpu_gnt,cpu_valid,cpu_rdata,host_gnt,host_valid,host_rdata,cpu_halt,ram_en,ram_we,ram_addr}
  typedef struct packed {
    logic [13:0] cin;
    logic [14:0] hin;
    logic [26:0] exp;
  } vec_t;

  localparam int NVEC = 29;
  localparam logic [13:0] CI0 = 14'h0;
  localparam logic [14:0] HI0 = 15'h0;
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [7:0] TIE_CRD = 8'h3C;
`else
  localparam logic [7:0] TIE_CRD = 8'h55;
`endif

  vec_t vecs [NVEC];

  function automatic logic [26:0] outs();
    return {cpu_gnt, cpu_valid, cpu_rdata, host_gnt, host_valid, host_rdata,
            cpu_halt, ram_en, ram_we, ram_addr};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("gnt_valid_exclusive", 64'((cpu_gnt && host_gnt) || (cpu_valid && host_valid)), 64'd0);
  endtask

  task automatic drive(input logic [13:0] c, input logic [14:0] h);
    {cpu_req, cpu_we, cpu_addr, cpu_wdata} = c;
    {host_req, host_we, host_addr, host_wdata, host_lock} = h;
  endtask

  initial begin
    vecs[0]  = '{CI0, {1'b1,1'b1,4'h5,8'h3C,1'b0}, {1'b0,1'b0,8'h00, 1'b1,1'b0,8'h00, 1'b0,1'b1,1'b1,4'h5}};
    vecs[1]  = '{CI0, HI0, {1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,4'h5}};
    vecs[2]  = '{{1'b1,1'b0,4'h5,8'h00}, HI0, {1'b1,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,4'h5}};
    vecs[3]  = '{CI0, HI0, {1'b0,1'b1,8'h3C, 1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,4'h5}};
    vecs[4]  = '{CI0, HI0, {1'b0,1'b0,8'h3C, 1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,4'h5}};
    vecs[5]  = '{CI0, {1'b1,1'b1,4'h2,8'hA7,1'b0}, {1'b0,1'b0,8'h3C, 1'b1,1'b0,8'h00, 1'b0,1'b1,1'b1,4'h2}};
    vecs[6]  = '{CI0, HI0, {1'b0,1'b0,8'h3C, 1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,4'h2}};
    vecs[7]  = '{{1'b1,1'b0,4'h2,8'h00}, HI0, {1'b1,1'b0,8'h3C, 1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,4'h2}};
    vecs[8]  = '{CI0, HI0, {1'b0,1'b1,8'hA7, 1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,4'h2}};
    vecs[9]  = '{CI0, HI0, {1'b0,1'b0,8'hA7, 1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,4'h2}};
    vecs[10] = '{CI0, {1'b1,1'b0,4'h5,8'h00,1'b0}, {1'b0,1'b0,8'hA7, 1'b1,1'b0,8'h00, 1'b0,1'b1,1'b0,4'h5}};
    vecs[11] = '{CI0, HI0, {1'b0,1'b0,8'hA7, 1'b0,1'b1,8'h3C, 1'b0,1'b0,1'b0,4'h5}};
    vecs[12] = '{CI0, HI0, {1'b0,1'b0,8'hA7, 1'b0,1'b0,8'h3C, 1'b0,1'b0,1'b0,4'h5}};
    vecs[13] = '{{1'b1,1'b1,4'h7,8'h55}, HI0, {1'b1,1'b0,8'hA7, 1'b0,1'b0,8'h3C, 1'b0,1'b1,1'b1,4'h7}};
    vecs[14] = '{CI0, HI0, {1'b0,1'b0,8'hA7, 1'b0,1'b0,8'h3C, 1'b0,1'b0,1'b0,4'h7}};
    vecs[15] = '{{1'b1,1'b0,4'h7,8'h00}, HI0, {1'b1,1'b0,8'hA7, 1'b0,1'b0,8'h3C, 1'b0,1'b1,1'b0,4'h7}};
    vecs[16] = '{{1'b1,1'b0,4'h7,8'h00}, HI0, {1'b0,1'b1,8'h55, 1'b0,1'b0,8'h3C, 1'b0,1'b0,1'b0,4'h7}};
    vecs[17] = '{{1'b1,1'b0,4'h7,8'h00}, HI0, {1'b1,1'b0,8'h55, 1'b0,1'b0,8'h3C, 1'b0,1'b1,1'b0,4'h7}};
    vecs[18] = '{CI0, HI0, {1'b0,1'b1,8'h55, 1'b0,1'b0,8'h3C, 1'b0,1'b0,1'b0,4'h7}};
    vecs[19] = '{CI0, HI0, {1'b0,1'b0,8'h55, 1'b0,1'b0,8'h3C, 1'b0,1'b0,1'b0,4'h7}};
    vecs[20] = '{{1'b1,1'b0,4'h5,8'h00}, {1'b1,1'b0,4'h2,8'h00,1'b0}, {1'b0,1'b0,8'h55, 1'b1,1'b0,8'h3C, 1'b0,1'b1,1'b0,4'h2}};
    vecs[21] = '{{1'b1,1'b0,4'h5,8'h00}, {1'b1,1'b0,4'h2,8'h00,1'b0}, {1'b0,1'b0,8'h55, 1'b0,1'b1,8'hA7, 1'b0,1'b0,1'b0,4'h2}};
`ifdef ARB_ROUND_ROBIN_EN
    vecs[22] = '{{1'b1,1'b0,4'h5,8'h00}, {1'b1,1'b0,4'h2,8'h00,1'b0}, {1'b1,1'b0,8'h55, 1'b0,1'b0,8'hA7, 1'b0,1'b1,1'b0,4'h5}};
    vecs[23] = '{{1'b1,1'b0,4'h5,8'h00}, {1'b1,1'b0,4'h2,8'h00,1'b0}, {1'b0,1'b1,8'h3C, 1'b0,1'b0,8'hA7, 1'b0,1'b0,1'b0,4'h5}};
    vecs[24] = '{{1'b1,1'b0,4'h5,8'h00}, {1'b1,1'b0,4'h2,8'h00,1'b0}, {1'b0,1'b0,8'h3C, 1'b1,1'b0,8'hA7, 1'b0,1'b1,1'b0,4'h2}};
    vecs[25] = '{{1'b1,1'b0,4'h5,8'h00}, {1'b1,1'b0,4'h2,8'h00,1'b0}, {1'b0,1'b0,8'h3C, 1'b0,1'b1,8'hA7, 1'b0,1'b0,1'b0,4'h2}};
`else
    vecs[22] = '{{1'b1,1'b0,4'h5,8'h00}, {1'b1,1'b0,4'h2,8'h00,1'b0}, {1'b0,1'b0,8'h55, 1'b1,1'b0,8'hA7, 1'b0,1'b1,1'b0,4'h2}};
    vecs[23] = '{{1'b1,1'b0,4'h5,8'h00}, {1'b1,1'b0,4'h2,8'h00,1'b0}, {1'b0,1'b0,8'h55, 1'b0,1'b1,8'hA7, 1'b0,1'b0,1'b0,4'h2}};
    vecs[24] = '{{1'b1,1'b0,4'h5,8'h00}, {1'b1,1'b0,4'h2,8'h00,1'b0}, {1'b0,1'b0,8'h55, 1'b1,1'b0,8'hA7, 1'b0,1'b1,1'b0,4'h2}};
    vecs[25] = '{{1'b1,1'b0,4'h5,8'h00}, {1'b1,1'b0,4'h2,8'h00,1'b0}, {1'b0,1'b0,8'h55, 1'b0,1'b1,8'hA7, 1'b0,1'b0,1'b0,4'h2}};
`endif
    vecs[26] = '{{1'b1,1'b0,4'h5,8'h00}, HI0, {1'b1,1'b0,TIE_CRD, 1'b0,1'b0,8'hA7, 1'b0,1'b1,1'b0,4'h5}};
    vecs[27] = '{CI0, HI0, {1'b0,1'b1,8'h3C, 1'b0,1'b0,8'hA7, 1'b0,1'b0,1'b0,4'h5}};
    vecs[28] = '{CI0, HI0, {1'b0,1'b0,8'h3C, 1'b0,1'b0,8'hA7, 1'b0,1'b0,1'b0,4'h5}};

    resetn = 1'b0;
    drive(CI0, HI0);
    tick();
    tick();
    check("reset_outputs", 64'(outs()), 64'd0);
    check("reset_wdata", 64'(ram_wdata), 64'd0);
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].cin, vecs[i].hin);
      tick();
      check($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
    end

    // host lock burst over all addresses with the CPU requesting throughout
    for (int i = 0; i < 16; i++) begin
      drive({1'b1,1'b0,4'h0,8'h00}, {1'b1,1'b1,4'(i),8'(8'h80 + i),1'b1});
      tick();
      check($sformatf("burst%0d_gnt", i), 64'({cpu_gnt, host_gnt, cpu_halt}), 64'({1'b0, 1'b1, (i != 0)}));
      check($sformatf("burst%0d_ram", i), 64'({ram_we, ram_addr, ram_wdata}), 64'({1'b1, 4'(i), 8'(8'h80 + i)}));
      drive({1'b1,1'b0,4'h0,8'h00}, {1'b0,1'b1,4'(i),8'(8'h80 + i),1'b1});
      tick();
      check($sformatf("burst%0d_locked", i), 64'({cpu_gnt, host_gnt, cpu_halt, ram_en}), 64'({1'b0, 1'b0, 1'b1, 1'b0}));
    end
    drive({1'b1,1'b0,4'h0,8'h00}, HI0);
    tick();
    check("lock_release_halt", 64'(cpu_halt), 64'd0);
    begin
      int n = 1;
      while (!cpu_gnt && n < 2) begin
        tick();
        n++;
      end
    end
    check("lock_release_cpu_gnt", 64'({cpu_gnt, ram_addr, ram_we}), 64'({1'b1, 4'h0, 1'b0}));
    drive(CI0, HI0);
    tick();
    check("burst_readback", 64'({cpu_valid, cpu_rdata}), 64'({1'b1, 8'h80}));

    // reset while a locked host read grant is in flight
    drive(CI0, {1'b1,1'b0,4'h2,8'h00,1'b1});
    tick();
    check("lk_first_gnt", 64'({host_gnt, cpu_halt}), 64'({1'b1, 1'b0}));
    drive(CI0, {1'b0,1'b0,4'h2,8'h00,1'b1});
    tick();
    check("lk_locked", 64'({cpu_halt, host_valid, host_rdata}), 64'({1'b1, 1'b1, 8'h82}));
    drive(CI0, {1'b1,1'b0,4'h5,8'h00,1'b1});
    tick();
    check("lk_second_gnt", 64'({host_gnt, cpu_halt, ram_en}), 64'({1'b1, 1'b1, 1'b1}));
    resetn = 1'b0;
    drive(CI0, HI0);
    tick();
    check("lk_reset_outputs", 64'({outs(), ram_wdata}), 64'd0);
    resetn = 1'b1;
    tick();
    check("lk_no_pending_valid", 64'(outs()), 64'd0);
    drive({1'b1,1'b0,4'h5,8'h00}, HI0);
    tick();
    check("lk_idle_after_reset", 64'({cpu_gnt, cpu_halt, ram_en}), 64'({1'b1, 1'b0, 1'b1}));
    drive(CI0, HI0);
    tick();
    check("lk_idle_read", 64'({cpu_valid, cpu_rdata}), 64'({1'b1, 8'h85}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: resetn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: cpu_req  in  1, cpu_we  in  1, cpu_addr  in  4, cpu_wdata  in  8  (CPU request, write enable, address, write data).
REQ-004 SHALL have ports: cpu_gnt  out  1, cpu_valid  out  1, cpu_rdata  out  8  (CPU grant pulse, read-data valid pulse, read data).
REQ-005 SHALL have ports: host_req  in  1, host_we  in  1, host_addr  in  4, host_wdata  in  8, host_lock  in  1  (host loader request fields; lock holds the RAM for a burst).
REQ-006 SHALL have ports: host_gnt  out  1, host_valid  out  1, host_rdata  out  8.
REQ-007 SHALL have ports: cpu_halt  out  1  (stalls the CPU stage counter while the host owns RAM).
REQ-008 SHALL have ports: ram_en  out  1, ram_we  out  1, ram_addr  out  4, ram_wdata  out  8, ram_rdata  in  8  (16x8 synchronous RAM, read data 1 cycle after ram_en).

Function
REQ-009 SHALL implement FSM states IDLE, GNT_CPU, GNT_HOST, LOCKED; all outputs registered.
REQ-010 In IDLE, with only cpu_req=1, SHALL capture cpu_addr/cpu_wdata/cpu_we and enter GNT_CPU next cycle; with only host_req=1, the same for host and GNT_HOST.
REQ-011 In GNT_x, SHALL drive x_gnt=1, ram_en=1, ram_we/ram_addr/ram_wdata from captured fields, for exactly one cycle.
REQ-012 For a read grant, SHALL pulse x_valid=1 one cycle after x_gnt, with x_rdata=ram_rdata; x_rdata SHALL hold until the next read by the same requester; writes SHALL produce no valid pulse.
REQ-013 GNT_CPU SHALL return to IDLE; GNT_HOST SHALL go to LOCKED if host_lock=1 in that cycle, else IDLE; back-to-back accesses therefore cost 2 cycles each.
REQ-014 In LOCKED, SHALL assert cpu_halt=1, ignore cpu_req, and serve host_req directly (LOCKED -> GNT_HOST); with host_req=0 and host_lock=0, SHALL return to IDLE.
REQ-015 cpu_halt SHALL be 1 in LOCKED and in GNT_HOST entered from LOCKED; 0 otherwise.
REQ-016 Requesters SHALL hold req and fields stable until gnt; a req still high in the cycle after gnt SHALL be treated as a new request.
REQ-017 Outside grant states, ram_en=0 and ram_we=0; ram_addr/ram_wdata hold their last value.
REQ-018 Simultaneous cpu_req and host_req in IDLE SHALL be resolved per REQ-022/REQ-023.
REQ-019 x_gnt and x_valid SHALL never be 1 for both requesters in the same cycle.

Reset
REQ-020 With resetn=0 at a rising edge, SHALL enter IDLE and clear all outputs to 0 (gnt, valid, rdata, cpu_halt, ram_*), clear captured fields, and set the round-robin pointer to "host last served".
REQ-021 Reset mid-grant or in LOCKED SHALL abort: no pending valid pulse is issued after reset; cpu_halt drops to 0 at that edge.

Configuration
REQ-022 With macro ARB_ROUND_ROBIN_EN defined, ties SHALL go to the requester not served last; the pointer updates on every grant.
REQ-023 Without ARB_ROUND_ROBIN_EN, ties SHALL always go to host (fixed priority); no pointer register exists.

Verification
REQ-024 CPU read: RAM[5]=0x3C, cpu_req=1, cpu_we=0, cpu_addr=5 -> cpu_gnt at +1 cycle, cpu_valid=1 with cpu_rdata=0x3C at +2.
REQ-025 Host write then CPU read: host writes 0xA7 to addr 2 -> host_gnt, no host_valid; CPU read addr 2 returns 0xA7.
REQ-026 Tie, RR enabled: cpu_req and host_req held high after reset -> grants alternate CPU, HOST, CPU, HOST; RR disabled -> host granted every time until host_req drops.
REQ-027 Lock burst: host_lock=1, host writes addrs 0..15 with cpu_req=1 throughout -> cpu_halt=1 and no cpu_gnt until host_lock=0 and host_req=0, then cpu_gnt within 2 cycles.
REQ-028 Reset in LOCKED during host read grant -> next cycle all outputs 0, no host_valid, state IDLE.
